// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered grant that is held until accepted, plus optional bounded burst locking.
// Define RR_ARBITER_STATS_EN to build the transfer/stall counters; otherwise stat_* are tied to 0.
module rr_arbiter #(
    parameter int REQS     = 8,
    parameter int MAX_HOLD = 4,
    localparam int IW      = $clog2(REQS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REQS-1:0] req,
    input  logic [REQS-1:0] lock,
    input  logic            out_ready,
    output logic [REQS-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_valid,
    output logic            xfer,
    output logic [31:0]     stat_xfers,
    output logic [31:0]     stat_stalls
);

    localparam int HW = $clog2(MAX_HOLD) + 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    // Masked search over indices >= p, falling back to a plain lowest-index search.
    function automatic logic [IW-1:0] win(input logic [REQS-1:0] r, input logic [IW-1:0] p);
        logic [REQS-1:0] m;
        logic [IW-1:0]   lo_m;
        logic [IW-1:0]   lo_r;
        m    = r & ~((REQS'(1) << p) - REQS'(1));
        lo_m = '0;
        lo_r = '0;
        for (int i = REQS - 1; i >= 0; i--) begin
            if (m[i]) lo_m = IW'(i);
            if (r[i]) lo_r = IW'(i);
        end
        return (|m) ? lo_m : lo_r;
    endfunction

    state_t          r_state;
    logic [REQS-1:0] r_gnt;
    logic [IW-1:0]   r_gnt_idx;
    logic            r_gnt_valid;
    logic [IW-1:0]   r_ptr;
    logic [HW-1:0]   r_hold;

    state_t          w_state_n;
    logic [REQS-1:0] w_gnt_n;
    logic [IW-1:0]   w_gnt_idx_n;
    logic            w_gnt_valid_n;
    logic [IW-1:0]   w_ptr_n;
    logic [HW-1:0]   w_hold_n;

    logic            w_xfer;
    logic [IW-1:0]   w_win_ptr;
    logic [IW-1:0]   w_ptr_inc;
    logic [IW-1:0]   w_win_next;
    logic            w_burst;

    assign w_xfer     = r_gnt_valid & out_ready & req[r_gnt_idx] & ~rst;
    assign w_win_ptr  = win(req, r_ptr);
    assign w_ptr_inc  = r_gnt_idx + IW'(1);
    assign w_win_next = win(req, w_ptr_inc);
    assign w_burst    = lock[r_gnt_idx] && (r_hold < HW'(MAX_HOLD - 1));

    // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_n     = r_state;
        w_gnt_n       = r_gnt;
        w_gnt_idx_n   = r_gnt_idx;
        w_gnt_valid_n = r_gnt_valid;
        w_ptr_n       = r_ptr;
        w_hold_n      = r_hold;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_n     = S_GRANT;
                    w_gnt_idx_n   = w_win_ptr;
                    w_gnt_n       = REQS'(1) << w_win_ptr;
                    w_gnt_valid_n = 1'b1;
                    w_hold_n      = '0;
                end
            end
            S_GRANT: begin
                if (!req[r_gnt_idx]) begin
                    w_state_n     = S_IDLE;
                    w_gnt_valid_n = 1'b0;
                    w_gnt_n       = '0;
                end else if (out_ready) begin
                    if (w_burst) begin
                        w_hold_n = r_hold + HW'(1);
                    end else begin
                        // The owner's own bit keeps req non-zero here, so a release always regrants.
                        w_ptr_n     = w_ptr_inc;
                        w_gnt_idx_n = w_win_next;
                        w_gnt_n     = REQS'(1) << w_win_next;
                        w_hold_n    = '0;
                    end
                end
            end
            default: begin
                w_state_n     = S_IDLE;
                w_gnt_valid_n = 1'b0;
                w_gnt_n       = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= '0;
            r_hold      <= '0;
        end else begin
            r_state     <= w_state_n;
            r_gnt       <= w_gnt_n;
            r_gnt_idx   <= w_gnt_idx_n;
            r_gnt_valid <= w_gnt_valid_n;
            r_ptr       <= w_ptr_n;
            r_hold      <= w_hold_n;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign xfer      = w_xfer;

`ifdef RR_ARBITER_STATS_EN
    logic [31:0] r_stat_xfers;
    logic [31:0] r_stat_stalls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_xfers  <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_xfer) r_stat_xfers <= r_stat_xfers + 32'd1;
            if (r_gnt_valid && !out_ready && req[r_gnt_idx]) r_stat_stalls <= r_stat_stalls + 32'd1;
        end
    end

    assign stat_xfers  = r_stat_xfers;
    assign stat_stalls = r_stat_stalls;
`else
    assign stat_xfers  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (REQS=4, MAX_HOLD=4): directed scenarios plus a randomized run
// against a rotating-search reference model.
module tb_rr_arbiter;

    localparam int REQS     = 4;
    localparam int MAX_HOLD = 4;
    localparam int IW       = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [REQS-1:0] req;
    logic [REQS-1:0] lock;
    logic            out_ready;
    logic [REQS-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_valid;
    logic            xfer;
    logic [31:0]     stat_xfers;
    logic [31:0]     stat_stalls;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: owner, pointer and burst length kept as plain integers.
    bit          m_valid;
    int          m_idx;
    int          m_ptr;
    int          m_hold;
    int unsigned m_xfers;
    int unsigned m_stalls;

    rr_arbiter #(.REQS(REQS), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .lock       (lock),
        .out_ready  (out_ready),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid),
        .xfer       (xfer),
        .stat_xfers (stat_xfers),
        .stat_stalls(stat_stalls)
    );

    always #5 clk = ~clk;

    // First requester met when walking upward from p and wrapping around.
    function automatic int pick(input logic [REQS-1:0] r, input int p);
        for (int k = 0; k < REQS; k++) begin
            if (r[(p + k) % REQS]) return (p + k) % REQS;
        end
        return 0;
    endfunction

    task automatic model_step();
        if (m_valid && out_ready && req[m_idx]) m_xfers++;
        if (m_valid && !out_ready && req[m_idx]) m_stalls++;
        if (!m_valid) begin
            if (req != 0) begin
                m_valid = 1'b1;
                m_idx   = pick(req, m_ptr);
                m_hold  = 0;
            end
        end else if (!req[m_idx]) begin
            m_valid = 1'b0;
        end else if (out_ready) begin
            if (lock[m_idx] && m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end else begin
                m_ptr = (m_idx + 1) % REQS;
                if (req != 0) begin
                    m_idx  = pick(req, m_ptr);
                    m_hold = 0;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        lock      = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst      = 1'b0;
        m_valid  = 1'b0;
        m_idx    = 0;
        m_ptr    = 0;
        m_hold   = 0;
        m_xfers  = 0;
        m_stalls = 0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst       = 1'b1;
        req       = 4'b1111;
        lock      = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        got = {gnt_valid, gnt, gnt_idx, xfer};
        n_total++;
        if (got !== 8'd0) $display("FAIL reset_outputs: got v/gnt/idx/xfer=%b want %b", got, 8'd0);
        else n_pass++;
        n_total++;
        if ({stat_xfers, stat_stalls} !== 64'd0)
            $display("FAIL reset_stats: got xfers=%0d stalls=%0d want 0 0", stat_xfers, stat_stalls);
        else n_pass++;
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_rotation();
        int         seq[6] = '{0, 1, 2, 3, 0, 1};
        logic [7:0] got, want;
        do_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (gnt_valid !== 1'b0) $display("FAIL rotation_latency: got gnt_valid=%b want 0", gnt_valid);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            got  = {gnt_valid, gnt, gnt_idx, xfer};
            want = {1'b1, 4'b0001 << seq[i], IW'(seq[i]), 1'b1};
            n_total++;
            if (got !== want) $display("FAIL rotation[%0d]: got v/gnt/idx/xfer=%b want %b", i, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int         seq[4] = '{1, 3, 1, 3};
        logic [7:0] got, want;
        do_reset();
        req       = 4'b1010;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got  = {gnt_valid, gnt, gnt_idx, xfer};
            want = {1'b1, 4'b0001 << seq[i], IW'(seq[i]), 1'b1};
            n_total++;
            if (got !== want) $display("FAIL wrap[%0d]: got v/gnt/idx/xfer=%b want %b", i, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_burst();
        int         seq[6] = '{0, 2, 2, 2, 2, 0};
        logic [7:0] got, want;
        do_reset();
        req       = 4'b0101;
        lock      = 4'b0100;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            got  = {gnt_valid, gnt, gnt_idx, xfer};
            want = {1'b1, 4'b0001 << seq[i], IW'(seq[i]), 1'b1};
            n_total++;
            if (got !== want) $display("FAIL burst[%0d]: got v/gnt/idx/xfer=%b want %b", i, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [7:0]  got;
        logic [63:0] want_stats;
        do_reset();
        req       = 4'b0010;
        out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {gnt_valid, gnt, gnt_idx, xfer};
            n_total++;
            if (got !== 8'b1_0010_01_0) $display("FAIL stall[%0d]: got v/gnt/idx/xfer=%b want %b", i, got, 8'b1_0010_01_0);
            else n_pass++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        req       = 4'b1111;
        @(negedge clk);
        got = {gnt_valid, gnt, gnt_idx, xfer};
        n_total++;
        if (got !== 8'b1_0010_01_1) $display("FAIL stall_release: got v/gnt/idx/xfer=%b want %b", got, 8'b1_0010_01_1);
        else n_pass++;
`ifdef RR_ARBITER_STATS_EN
        want_stats = {32'd0, 32'd3};
`else
        want_stats = 64'd0;
`endif
        n_total++;
        if ({stat_xfers, stat_stalls} !== want_stats)
            $display("FAIL stall_stats: got xfers=%0d stalls=%0d want %0d %0d",
                     stat_xfers, stat_stalls, want_stats[63:32], want_stats[31:0]);
        else n_pass++;
        @(negedge clk);
        got = {gnt_valid, gnt, gnt_idx, xfer};
        n_total++;
        if (got !== 8'b1_0100_10_1) $display("FAIL stall_next_ptr: got v/gnt/idx/xfer=%b want %b", got, 8'b1_0100_10_1);
        else n_pass++;
    endtask

    task automatic test_withdraw();
        logic [7:0] got;
        do_reset();
        req       = 4'b0010;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        got = {gnt_valid, gnt, gnt_idx, xfer};
        n_total++;
        if (got !== 8'b1_0010_01_0) $display("FAIL withdraw_grant: got v/gnt/idx/xfer=%b want %b", got, 8'b1_0010_01_0);
        else n_pass++;
        @(posedge clk); #1;
        req = 4'b1000;
        @(negedge clk);
        n_total++;
        if (xfer !== 1'b0) $display("FAIL withdraw_noxfer: got xfer=%b want 0", xfer);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({gnt_valid, gnt} !== 5'd0) $display("FAIL withdraw_cancel: got v/gnt=%b want %b", {gnt_valid, gnt}, 5'd0);
        else n_pass++;
        @(negedge clk);
        got = {gnt_valid, gnt, gnt_idx, xfer};
        n_total++;
        if (got !== 8'b1_1000_11_0) $display("FAIL withdraw_regrant: got v/gnt/idx/xfer=%b want %b", got, 8'b1_1000_11_0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_grant();
        logic [7:0] got;
        do_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        got = {gnt_valid, gnt, gnt_idx, xfer};
        n_total++;
        if (got !== 8'b1_0001_00_1) $display("FAIL midreset_pre: got v/gnt/idx/xfer=%b want %b", got, 8'b1_0001_00_1);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (xfer !== 1'b0) $display("FAIL midreset_xfer: got xfer=%b want 0", xfer);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        got = {gnt_valid, gnt, gnt_idx, xfer};
        n_total++;
        if (got !== 8'd0 || {stat_xfers, stat_stalls} !== 64'd0)
            $display("FAIL midreset_post: got v/gnt/idx/xfer=%b xfers=%0d stalls=%0d want 0 0 0",
                     got, stat_xfers, stat_stalls);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [REQS-1:0] r;
        logic [5:0]      got, want;
        bit              prev_xfer = 1'b0;
        int              prev_idx  = 0;
        bit              e_xfer;
        do_reset();
        r = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 2) == 0) r = r | REQS'($urandom);
            if (prev_xfer && $urandom_range(0, 1) == 1) r[prev_idx] = 1'b0;
            if ($urandom_range(0, 15) == 0) r = r & REQS'($urandom);
            req       = r;
            lock      = REQS'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_xfer = m_valid && out_ready && req[m_idx];
            got    = {gnt_valid, gnt, xfer};
            want   = {m_valid, m_valid ? (4'b0001 << m_idx) : 4'b0000, e_xfer};
            n_total++;
            if (got !== want) $display("FAIL random[%0d]: got v/gnt/xfer=%b want %b", cyc, got, want);
            else n_pass++;
            if (m_valid) begin
                n_total++;
                if (gnt_idx !== IW'(m_idx)) $display("FAIL random_idx[%0d]: got %0d want %0d", cyc, gnt_idx, m_idx);
                else n_pass++;
            end
`ifdef RR_ARBITER_STATS_EN
            n_total++;
            if (stat_xfers !== m_xfers || stat_stalls !== m_stalls)
                $display("FAIL random_stats[%0d]: got xfers=%0d stalls=%0d want %0d %0d",
                         cyc, stat_xfers, stat_stalls, m_xfers, m_stalls);
            else n_pass++;
`endif
            prev_xfer = e_xfer;
            prev_idx  = m_idx;
            model_step();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_burst();
        test_stall();
        test_withdraw();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
